// File: rtl/decode_stage_hz.sv
// Instruction-decode stage: control decode, immediate extension, register file with
// writeback bypass, load-use detection and the ID/EX pipeline register.

module Control_Unit (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       RegWrite,
  output logic       ResultSrc,
  output logic       MemWrite,
  output logic       Branch,
  output logic       ALUSrc,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl
);
  // ImmSrc: 00 I-type, 01 S-type, 10 B-type, 11 J-type; unknown opcodes decode as a no-op.
  always_comb begin
    RegWrite   = 1'b0;
    ResultSrc  = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    ALUSrc     = 1'b0;
    ImmSrc     = 2'b00;
    ALUControl = 4'h0;
    case (op)
      7'b0000011: begin
        RegWrite  = 1'b1;
        ResultSrc = 1'b1;
        ALUSrc    = 1'b1;
      end
      7'b0100011: begin
        MemWrite = 1'b1;
        ALUSrc   = 1'b1;
        ImmSrc   = 2'b01;
      end
      7'b0110011: begin
        RegWrite   = 1'b1;
        ALUControl = {funct7b5, funct3};
      end
      7'b0010011: begin
        RegWrite   = 1'b1;
        ALUSrc     = 1'b1;
        ALUControl = {(funct3 == 3'b101) & funct7b5, funct3};
      end
      7'b1100011: begin
        Branch     = 1'b1;
        ImmSrc     = 2'b10;
        ALUControl = 4'h8;
      end
      7'b1101111: begin
        RegWrite = 1'b1;
        ImmSrc   = 2'b11;
      end
      default: ;
    endcase
  end
endmodule

module Extend (
  input  logic [31:7] instr,
  input  logic [1:0]  ImmSrc,
  output logic [31:0] ImmExt
);
  always_comb begin
    case (ImmSrc)
      2'b00:   ImmExt = {{20{instr[31]}}, instr[31:20]};
      2'b01:   ImmExt = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10:   ImmExt = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: ImmExt = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  end
endmodule

module decode_stage_hz #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ValidD,
  input  logic [31:0]               InstrD,
  input  logic [XLEN-1:0]           PCD,
  input  logic                      RegWriteW,
  input  logic [$clog2(NREG)-1:0]   RDW,
  input  logic [XLEN-1:0]           ResultW,
  input  logic                      FlushE,
  input  logic                      HoldE,
  output logic                      StallD,
  output logic                      ValidE,
  output logic                      RegWriteE,
  output logic                      ResultSrcE,
  output logic                      MemWriteE,
  output logic                      BranchE,
  output logic                      ALUSrcE,
  output logic [3:0]                ALUControlE,
  output logic [$clog2(NREG)-1:0]   RDE,
  output logic [$clog2(NREG)-1:0]   RS1E,
  output logic [$clog2(NREG)-1:0]   RS2E,
  output logic [XLEN-1:0]           RD1E,
  output logic [XLEN-1:0]           RD2E,
  output logic [XLEN-1:0]           PCE,
  output logic [XLEN-1:0]           ImmExtE,
  output logic [CNTW-1:0]           BubbleCnt
);
  localparam int RAW = $clog2(NREG);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            result_src;
    logic            mem_write;
    logic            branch;
    logic            alu_src;
    logic [3:0]      alu_control;
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } id_ex_t;

  logic [XLEN-1:0] regs [NREG];
  logic [RAW-1:0]  rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rd1_d, rd2_d;
  logic            wb_write;
  logic            load_use;
  logic            reg_write_d, result_src_d, mem_write_d, branch_d, alu_src_d;
  logic [1:0]      imm_src_d;
  logic [3:0]      alu_control_d;
  logic [31:0]     imm32_d;
  id_ex_t          ex_d, ex_q;

  Control_Unit u_control (
    .op         (InstrD[6:0]),
    .funct3     (InstrD[14:12]),
    .funct7b5   (InstrD[30]),
    .RegWrite   (reg_write_d),
    .ResultSrc  (result_src_d),
    .MemWrite   (mem_write_d),
    .Branch     (branch_d),
    .ALUSrc     (alu_src_d),
    .ImmSrc     (imm_src_d),
    .ALUControl (alu_control_d)
  );

  Extend u_extend (
    .instr  (InstrD[31:7]),
    .ImmSrc (imm_src_d),
    .ImmExt (imm32_d)
  );

  assign rs1_d    = InstrD[15 +: RAW];
  assign rs2_d    = InstrD[20 +: RAW];
  assign rd_d     = InstrD[7 +: RAW];
  assign wb_write = RegWriteW && (RDW != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[RDW] <= ResultW;
    end
  end

  // Write-first bypass lets the instruction in decode see this cycle's writeback.
  always_comb begin
    if (rs1_d == '0)                     rd1_d = '0;
    else if (wb_write && (RDW == rs1_d)) rd1_d = ResultW;
    else                                 rd1_d = regs[rs1_d];
    if (rs2_d == '0)                     rd2_d = '0;
    else if (wb_write && (RDW == rs2_d)) rd2_d = ResultW;
    else                                 rd2_d = regs[rs2_d];
  end

  assign load_use = ValidD && ex_q.valid && ex_q.reg_write && ex_q.result_src &&
                    (ex_q.rd != '0) && ((ex_q.rd == rs1_d) || (ex_q.rd == rs2_d));
  assign StallD   = load_use | HoldE;

  always_comb begin
    ex_d             = '0;
    ex_d.valid       = 1'b1;
    ex_d.reg_write   = reg_write_d;
    ex_d.result_src  = result_src_d;
    ex_d.mem_write   = mem_write_d;
    ex_d.branch      = branch_d;
    ex_d.alu_src     = alu_src_d;
    ex_d.alu_control = alu_control_d;
    ex_d.rd          = rd_d;
    ex_d.rs1         = rs1_d;
    ex_d.rs2         = rs2_d;
    ex_d.rd1         = rd1_d;
    ex_d.rd2         = rd2_d;
    ex_d.pc          = PCD;
    ex_d.imm         = XLEN'($signed(imm32_d));
  end

  // Hold beats flush, which beats the load-use bubble; any bubble clears every field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (HoldE) begin
      ex_q <= ex_q;
    end else if (FlushE || load_use || !ValidD) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BubbleCnt <= '0;
    end else if (!HoldE && !FlushE && load_use && (BubbleCnt != '1)) begin
      BubbleCnt <= BubbleCnt + 1'b1;
    end
  end

  assign ValidE      = ex_q.valid;
  assign RegWriteE   = ex_q.reg_write;
  assign ResultSrcE  = ex_q.result_src;
  assign MemWriteE   = ex_q.mem_write;
  assign BranchE     = ex_q.branch;
  assign ALUSrcE     = ex_q.alu_src;
  assign ALUControlE = ex_q.alu_control;
  assign RDE         = ex_q.rd;
  assign RS1E        = ex_q.rs1;
  assign RS2E        = ex_q.rs2;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign PCE         = ex_q.pc;
  assign ImmExtE     = ex_q.imm;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: directed hazard scenarios followed by random traffic,
// all checked against a behavioural model of the decode stage.

module tb_decode_stage_hz;
  logic        clk, rst;
  logic        ValidD, RegWriteW, FlushE, HoldE;
  logic [31:0] InstrD, PCD, ResultW;
  logic [4:0]  RDW;
  logic        StallD, ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [4:0]  RDE, RS1E, RS2E;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE;
  logic [1:0]  BubbleCnt;

  decode_stage_hz #(.XLEN(32), .NREG(32), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE), .HoldE(HoldE),
    .StallD(StallD), .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RDE(RDE), .RS1E(RS1E), .RS2E(RS2E), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .ImmExtE(ImmExtE), .BubbleCnt(BubbleCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit        valid, rw, rsrc, mw, br, asrc;
    bit [3:0]  alu;
    bit [4:0]  rd, rs1, rs2;
    bit [31:0] rd1, rd2, pc, imm;
  } ex_t;

  ex_t      mex;
  bit [31:0] mrf [32];
  int        mcnt;
  int        checks = 0;
  int        errors = 0;
  bit        lastStall;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Immediate value as a signed integer built from weighted instruction bits.
  function automatic bit [31:0] immModel(input int kind, input bit [31:0] ins);
    int sgn;
    sgn = ins[31] ? -1 : 0;
    case (kind)
      0: return sgn * 2048 + int'(ins[30:20]);
      1: return sgn * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
      2: return sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      default: return sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                      + int'(ins[30:21]) * 2;
    endcase
  endfunction

  function automatic ex_t decodeModel(input bit [31:0] ins, input bit [31:0] pc,
                                      input bit [31:0] a, input bit [31:0] b);
    ex_t e;
    e       = '0;
    e.valid = 1'b1;
    e.rd    = ins[11:7];
    e.rs1   = ins[19:15];
    e.rs2   = ins[24:20];
    e.rd1   = a;
    e.rd2   = b;
    e.pc    = pc;
    e.imm   = immModel(0, ins);
    case (ins[6:0])
      7'h03: begin e.rw = 1; e.rsrc = 1; e.asrc = 1; end
      7'h23: begin e.mw = 1; e.asrc = 1; e.imm = immModel(1, ins); end
      7'h33: begin e.rw = 1; e.alu = {ins[30], ins[14:12]}; end
      7'h13: begin
        e.rw = 1; e.asrc = 1;
        e.alu = (ins[14:12] == 3'd5) ? {ins[30], 3'd5} : {1'b0, ins[14:12]};
      end
      7'h63: begin e.br = 1; e.alu = 4'h8; e.imm = immModel(2, ins); end
      7'h6f: begin e.rw = 1; e.imm = immModel(3, ins); end
      default: ;
    endcase
    return e;
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ".ValidE"}, ValidE, mex.valid);
    checkOutput({tag, ".RegWriteE"}, RegWriteE, mex.rw);
    checkOutput({tag, ".ResultSrcE"}, ResultSrcE, mex.rsrc);
    checkOutput({tag, ".MemWriteE"}, MemWriteE, mex.mw);
    checkOutput({tag, ".BranchE"}, BranchE, mex.br);
    checkOutput({tag, ".ALUSrcE"}, ALUSrcE, mex.asrc);
    checkOutput({tag, ".ALUControlE"}, ALUControlE, mex.alu);
    checkOutput({tag, ".RDE"}, RDE, mex.rd);
    checkOutput({tag, ".RS1E"}, RS1E, mex.rs1);
    checkOutput({tag, ".RS2E"}, RS2E, mex.rs2);
    checkOutput({tag, ".RD1E"}, RD1E, mex.rd1);
    checkOutput({tag, ".RD2E"}, RD2E, mex.rd2);
    checkOutput({tag, ".PCE"}, PCE, mex.pc);
    checkOutput({tag, ".ImmExtE"}, ImmExtE, mex.imm);
    checkOutput({tag, ".BubbleCnt"}, BubbleCnt, mcnt);
  endtask

  task automatic resetModel();
    mex  = '0;
    mcnt = 0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
  endtask

  // One clock cycle: drive at the falling edge, check StallD, then check EX after the rise.
  task automatic applyStimulus(input bit v, input bit [31:0] ins, input bit [31:0] pc,
                               input bit rw, input bit [4:0] rdw, input bit [31:0] res,
                               input bit fl, input bit ho);
    bit [4:0]  r1, r2;
    bit [31:0] a, b;
    bit        lu;
    ex_t       nx;
    int        ncnt;
    @(negedge clk);
    rst = 1'b0; ValidD = v; InstrD = ins; PCD = pc;
    RegWriteW = rw; RDW = rdw; ResultW = res; FlushE = fl; HoldE = ho;
    #1;
    r1 = ins[19:15];
    r2 = ins[24:20];
    lu = v && mex.valid && mex.rw && mex.rsrc && (mex.rd != 0) && (mex.rd == r1 || mex.rd == r2);
    lastStall = StallD;
    checkOutput("StallD", StallD, lu || ho);
    a = (r1 == 0) ? 32'h0 : (rw && rdw == r1) ? res : mrf[r1];
    b = (r2 == 0) ? 32'h0 : (rw && rdw == r2) ? res : mrf[r2];
    ncnt = mcnt;
    if (ho) nx = mex;
    else if (fl || lu || !v) begin
      nx = '0;
      if (!fl && lu) ncnt = (mcnt == 3) ? 3 : mcnt + 1;
    end else nx = decodeModel(ins, pc, a, b);
    @(posedge clk);
    #1;
    mex  = nx;
    mcnt = ncnt;
    if (rw && rdw != 0) mrf[rdw] = res;
    compareAll("cyc");
  endtask

  function automatic bit [31:0] mkR(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic bit [31:0] mkLw(input bit [4:0] rd, input bit [4:0] rs1, input bit [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'h03};
  endfunction

  function automatic bit [31:0] randInstr();
    bit [4:0]  rd, r1, r2;
    bit [2:0]  f3;
    bit [31:0] w;
    rd = 5'($urandom % 8); r1 = 5'($urandom % 8); r2 = 5'($urandom % 8);
    f3 = 3'($urandom);
    w  = $urandom;
    case ($urandom % 8)
      0, 1: return mkLw(rd, r1, w[11:0]);
      2:    return {w[31:25], r2, r1, 3'b010, w[11:7], 7'h23};
      3:    return {1'b0, w[30], 5'b0, r2, r1, f3, rd, 7'h33};
      4:    return {w[31:20], r1, f3, rd, 7'h13};
      5:    return {w[31:25], r2, r1, f3, w[11:7], 7'h63};
      6:    return {w[31:12], rd, 7'h6f};
      default: return w;
    endcase
  endfunction

  initial begin : main
    int        seq [5] = '{1, 2, 3, 3, 3};
    bit [31:0] ins;
    bit        v;
    rst = 1'b1; ValidD = 0; InstrD = 0; PCD = 0; RegWriteW = 0; RDW = 0; ResultW = 0;
    FlushE = 0; HoldE = 0;
    resetModel();
    #2;
    compareAll("reset");

    // Load-use pairs: one bubble each, counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, mkLw(6, 1, 12'h0), 32'h100 + 8 * i, 0, 0, 0, 0, 0);
      applyStimulus(1, mkR(7, 6, 2), 32'h104 + 8 * i, 0, 0, 0, 0, 0);
      checkOutput("lu_stall", lastStall, 1);
      checkOutput("lu_bubble", ValidE, 0);
      checkOutput("cnt_sat", BubbleCnt, seq[i]);
      applyStimulus(1, mkR(7, 6, 2), 32'h104 + 8 * i, 0, 0, 0, 0, 0);
      checkOutput("lu_issue_stall", lastStall, 0);
      checkOutput("lu_issue_rd", RDE, 7);
    end

    // A load into x0 must not stall a consumer of x0.
    applyStimulus(1, mkLw(0, 1, 12'h4), 32'h200, 0, 0, 0, 0, 0);
    applyStimulus(1, mkR(7, 0, 0), 32'h204, 0, 0, 0, 0, 0);
    checkOutput("x0_stall", lastStall, 0);
    checkOutput("x0_valid", ValidE, 1);

    applyStimulus(1, mkR(4, 3, 0), 32'h208, 1, 3, 32'hDEADBEEF, 0, 0);
    checkOutput("bypass_rd1", RD1E, 32'hDEADBEEF);
    checkOutput("bypass_rd2", RD2E, 0);

    // Hold for three cycles with a flush pending from the second; bubble lands after release.
    applyStimulus(1, mkR(9, 1, 2), 32'h300, 0, 0, 0, 0, 0);
    applyStimulus(1, mkR(10, 3, 4), 32'h304, 0, 0, 0, 0, 1);
    checkOutput("hold_stall", lastStall, 1);
    checkOutput("hold_rd", RDE, 9);
    applyStimulus(1, mkR(10, 3, 4), 32'h304, 0, 0, 0, 1, 1);
    checkOutput("hold_flush_rd", RDE, 9);
    applyStimulus(1, mkR(10, 3, 4), 32'h304, 0, 0, 0, 1, 1);
    checkOutput("hold_flush_pc", PCE, 32'h300);
    applyStimulus(1, mkR(10, 3, 4), 32'h304, 0, 0, 0, 1, 0);
    checkOutput("flush_bubble", ValidE, 0);

    // Asynchronous reset between edges wipes EX state, counter and register file.
    applyStimulus(0, 32'h0, 32'h0, 1, 5, 32'h1234, 0, 0);
    applyStimulus(1, mkR(11, 5, 0), 32'h400, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    resetModel();
    compareAll("rst_mid");
    applyStimulus(1, mkR(8, 5, 0), 32'h404, 0, 0, 0, 0, 0);
    checkOutput("x5_after_rst", RD1E, 0);

    // Random traffic; a stalled IF/ID keeps presenting the same instruction.
    ins = randInstr();
    v   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!lastStall) begin
        ins = randInstr();
        v   = ($urandom % 10) != 0;
      end
      applyStimulus(v, ins, $urandom, ($urandom % 2) == 0, 5'($urandom % 8), $urandom,
                    ($urandom % 10) == 0, ($urandom % 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
